// File: rtl/psg_audio_mixer.sv
// PSG output stage: mixes the three channel levels, box-car decimates over
// 2^DECIM_LOG2 CE ticks, removes DC, applies gain with saturation.
module psg_audio_mixer #(
    parameter int unsigned DECIM_LOG2 = 4,
    parameter int unsigned DC_SHIFT   = 9
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CE,
    input  logic [7:0]         CH_A,
    input  logic [7:0]         CH_B,
    input  logic [7:0]         CH_C,
    input  logic [2:0]         MUTE,
    input  logic               DC_EN,
    input  logic [1:0]         GAIN,
    output logic signed [15:0] SAMPLE_OUT,
    output logic               SAMPLE_VALID,
    output logic               CLIP
);

    localparam int unsigned ACC_W = 10 + DECIM_LOG2;
    localparam int unsigned CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int unsigned DC_W  = 16 + DC_SHIFT;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic signed [15:0] MIDPOINT = 16'sd12240;
    localparam logic signed [18:0] POS_MAX  = 19'sd32767;
    localparam logic signed [18:0] NEG_MIN  = -19'sd32768;

    // Stage 0: mixing and window accumulation
    logic [9:0]       mix;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt;
    logic             window_end;
    logic [9:0]       avg;
    logic             pend;

    // Stage 1: DC removal, gain, saturation
    logic signed [DC_W-1:0] dc_acc;
    logic signed [DC_W-1:0] dc_acc_next;
    logic signed [15:0]     x;
    logic signed [15:0]     dc;
    logic signed [15:0]     y;
    logic signed [18:0]     z;
    logic signed [15:0]     sat;
    logic                   sat_hit;

    always_comb begin
        mix = (MUTE[0] ? 10'd0 : {2'b00, CH_A})
            + (MUTE[1] ? 10'd0 : {2'b00, CH_B})
            + (MUTE[2] ? 10'd0 : {2'b00, CH_C});
        acc_sum    = acc + ACC_W'(mix);
        window_end = (cnt == CNT_LAST);
    end

    always_comb begin
        x  = $signed({1'b0, avg, 5'b00000});
        dc = $signed(dc_acc[DC_W-1:DC_SHIFT]);
        if (DC_EN) begin
            y           = x - dc;
            dc_acc_next = dc_acc + $signed({{DC_SHIFT{y[15]}}, y});
        end else begin
            y           = x - MIDPOINT;
            dc_acc_next = '0;
        end
        // One guard bit beyond 18 so a large tracked-DC residual shifted by 3 cannot wrap
        z = $signed({{3{y[15]}}, y}) <<< GAIN;
        if (z > POS_MAX) begin
            sat     = 16'sh7FFF;
            sat_hit = 1'b1;
        end else if (z < NEG_MIN) begin
            sat     = 16'sh8000;
            sat_hit = 1'b1;
        end else begin
            sat     = z[15:0];
            sat_hit = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc          <= '0;
            cnt          <= '0;
            avg          <= '0;
            pend         <= 1'b0;
            dc_acc       <= '0;
            SAMPLE_OUT   <= '0;
            SAMPLE_VALID <= 1'b0;
            CLIP         <= 1'b0;
        end else begin
            if (pend) begin
                SAMPLE_OUT   <= sat;
                CLIP         <= sat_hit;
                SAMPLE_VALID <= 1'b1;
                dc_acc       <= dc_acc_next;
                pend         <= 1'b0;
            end else begin
                SAMPLE_VALID <= 1'b0;
            end
            // Stage 0 follows stage 1 so a window closing on an emit edge re-arms pend
            if (CE) begin
                if (window_end) begin
                    avg  <= acc_sum[ACC_W-1:DECIM_LOG2];
                    pend <= 1'b1;
                    acc  <= '0;
                    cnt  <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_psg_audio_mixer.sv
// Directed, table-driven bench for psg_audio_mixer (DECIM_LOG2=4, DC_SHIFT=9).
module tb_psg_audio_mixer;

    logic               clk = 1'b0;
    logic               reset;
    logic               ce;
    logic [7:0]         ch_a, ch_b, ch_c;
    logic [2:0]         mute;
    logic               dc_en;
    logic [1:0]         gain;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               clip;

    always #5 clk = ~clk;

    psg_audio_mixer #(.DECIM_LOG2(4), .DC_SHIFT(9)) dut (
        .CLK(clk), .RESET(reset), .CE(ce),
        .CH_A(ch_a), .CH_B(ch_b), .CH_C(ch_c),
        .MUTE(mute), .DC_EN(dc_en), .GAIN(gain),
        .SAMPLE_OUT(sample_out), .SAMPLE_VALID(sample_valid), .CLIP(clip)
    );

    int n_vec = 0;
    int n_err = 0;

    int                 valid_cnt   = 0;
    int                 ce_seen     = 0;
    int                 ce_at_valid = 0;
    int                 run_err     = 0;
    bit                 prev_valid  = 1'b0;
    logic signed [15:0] mon_out     = '0;
    logic               mon_clip    = 1'b0;

    // Observe 2 ns after each rising edge; CE count is per window-closing edge
    always @(posedge clk) begin
        #2;
        if (reset) begin
            ce_seen    = 0;
            prev_valid = 1'b0;
        end else begin
            if (sample_valid) begin
                valid_cnt++;
                mon_out     = sample_out;
                mon_clip    = clip;
                ce_at_valid = ce_seen;
                if (prev_valid) run_err++;
            end
            prev_valid = sample_valid;
            if (ce) ce_seen++;
        end
    end

    typedef struct {
        logic [7:0] a, b, c;
        logic [2:0] mute;
        logic [1:0] gain;
        int         spacing;
        int         exp_out;
        bit         exp_clip;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int spacing, input bit last);
        @(negedge clk) ce = 1'b1;
        @(negedge clk) ce = 1'b0;
        if (!last) repeat (spacing - 1) @(negedge clk);
    endtask

    task automatic wait_valid(input int old, input int bound, output bit ok);
        for (int k = 0; k < bound; k++) begin
            if (valid_cnt != old) break;
            @(negedge clk);
        end
        ok = (valid_cnt == old + 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        int old;
        int v, prev, viol, neg;
        bit reached;

        reset = 1'b1; ce = 1'b0;
        ch_a = '0; ch_b = '0; ch_c = '0;
        mute = '0; dc_en = 1'b0; gain = '0;

        //        a      b      c      mute    gain sp  exp     clip
        vecs[0] = '{8'h00, 8'h00, 8'h00, 3'b000, 2'd0, 4, -12240, 1'b0};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 3'b000, 2'd0, 2,  12240, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 3'b000, 2'd2, 2,  32767, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 3'b000, 2'd1, 2,  24480, 1'b0};
        vecs[4] = '{8'h80, 8'hFF, 8'hFF, 3'b110, 2'd0, 2,  -8144, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 8'hFF, 3'b111, 2'd0, 2, -12240, 1'b0};
        vecs[6] = '{8'h01, 8'hFF, 8'hFF, 3'b110, 2'd3, 2, -32768, 1'b1};
        vecs[7] = '{8'h55, 8'h55, 8'h55, 3'b000, 2'd1, 2,  -8160, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_out", sample_out, 0);
        check("reset_valid", {31'd0, sample_valid}, 0);
        check("reset_clip", {31'd0, clip}, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            ch_a = vecs[i].a; ch_b = vecs[i].b; ch_c = vecs[i].c;
            mute = vecs[i].mute; gain = vecs[i].gain;
            old = valid_cnt;
            for (int t = 0; t < 16; t++) tick(vecs[i].spacing, t == 15);
            wait_valid(old, 8, ok);
            check($sformatf("vec%0d_valid", i), {31'd0, ok}, 1);
            check($sformatf("vec%0d_out", i), mon_out, vecs[i].exp_out);
            check($sformatf("vec%0d_clip", i), {31'd0, mon_clip}, {31'd0, vecs[i].exp_clip});
            check($sformatf("vec%0d_ce_count", i), ce_at_valid, 16 * (i + 1));
        end

        // Alternating full-scale / silence per tick: 8*765/16 floors to 382
        mute = '0; gain = '0;
        old = valid_cnt;
        for (int t = 0; t < 16; t++) begin
            ch_a = (t % 2 == 1) ? 8'hFF : 8'h00;
            ch_b = ch_a; ch_c = ch_a;
            tick(2, t == 15);
        end
        wait_valid(old, 8, ok);
        check("alt_valid", {31'd0, ok}, 1);
        check("alt_out", mon_out, -16);
        check("alt_clip", {31'd0, mon_clip}, 0);

        // Reset after 7 ticks discards the partial window
        ch_a = '0; ch_b = '0; ch_c = '0;
        for (int t = 0; t < 7; t++) tick(1, 1'b0);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check("rst_mid_out", sample_out, 0);
        check("rst_mid_clip", {31'd0, clip}, 0);
        old = valid_cnt;
        ce = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_no_early_valid", valid_cnt, old);
        check("rst_hold_out", sample_out, 0);
        @(negedge clk) ce = 1'b0;
        check("rst_latency_pre", valid_cnt, old);
        @(negedge clk);
        check("rst_latency_post", valid_cnt, old + 1);
        check("rst_first_out", mon_out, -12240);
        check("rst_first_ce", ce_at_valid, 16);

        // Adaptive DC removal with constant full-scale input, continuous CE
        reset = 1'b1;
        ch_a = 8'hFF; ch_b = 8'hFF; ch_c = 8'hFF;
        mute = '0; dc_en = 1'b1; gain = '0;
        @(negedge clk) reset = 1'b0;
        ce = 1'b1;
        prev = 0; viol = 0; neg = 0; reached = 1'b0;
        for (int s = 0; s < 3200; s++) begin
            old = valid_cnt;
            wait_valid(old, 40, ok);
            if (!ok) begin
                check("dc_valid", 0, 1);
                break;
            end
            v = mon_out;
            if (s == 0) check("dc_first", v, 24480);
            if (s == 1) check("dc_second", v, 24433);
            if (s > 0 && v > prev) viol++;
            if (v < 0) neg++;
            if (((v < 0) ? -v : v) < 64) reached = 1'b1;
            prev = v;
        end
        ce = 1'b0;
        check("dc_monotonic", viol, 0);
        check("dc_nonneg", neg, 0);
        check("dc_settled", {31'd0, reached}, 1);
        check("valid_single_cycle", run_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
